imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: DEPTH, 1024, instruction memory size in 32-bit words (word index width AW = log2(DEPTH) = 10).
REQ-002 Parameter: STARVE_MAX, 4, consecutive fetch grants tolerated while a load is pending.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 fetch_req  in  1  core requests an instruction read.
REQ-006 fetch_addr  in  32  byte address of the fetch.
REQ-007 fetch_gnt  out  1  fetch accepted this cycle.
REQ-008 fetch_valid  out  1  fetch_data valid; one-cycle pulse.
REQ-009 fetch_data  out  32  instruction word.
REQ-010 fetch_err  out  1  one-cycle pulse: misaligned or out-of-range fetch.
REQ-011 load_req  in  1  loader requests a word write.
REQ-012 load_addr  in  32  byte address of the write.
REQ-013 load_data  in  32  word to write.
REQ-014 load_gnt  out  1  write accepted this cycle.
REQ-015 load_done  in  1  pulse: loader finished boot image.
REQ-016 running  out  1  high in RUN state.
REQ-017 load_count  out  AW+1  number of words written since reset.
REQ-018 mem_en, mem_we  out  1 each  memory port enable and write enable.
REQ-019 mem_addr  out  AW  word index; mem_wdata out 32; mem_rdata in 32 (synchronous read, data one cycle after mem_en with mem_we=0).

Function
REQ-020 The memory port SHALL carry at most one operation per cycle; mem_en = fetch_gnt | load_gnt, and mem_we = load_gnt.
REQ-021 mem_addr SHALL be addr[AW+1:2] of the granted requester; mem_wdata SHALL equal load_data.
REQ-022 FSM states: BOOT (reset state), RUN; BOOT->RUN on load_done; RUN is terminal until reset.
REQ-023 In BOOT, fetch_gnt SHALL be 0; load_gnt = load_req & addr legal.
REQ-024 In RUN, fetch has priority: fetch_gnt = fetch_req & legal & ~force_load; load_gnt = load_req & legal & ~fetch_gnt.
REQ-025 Starvation counter SHALL increment on each fetch_gnt while load_req is high, and clear on load_gnt or when load_req is low; force_load = (counter == STARVE_MAX).
REQ-026 When force_load is high, the fetch SHALL NOT be granted that cycle and SHALL be retried by the requester (request held).
REQ-027 Legal address: addr[1:0]==0 and addr < 4*DEPTH; an illegal fetch SHALL produce fetch_err the next cycle, no grant, no memory access.
REQ-028 An illegal load SHALL be dropped: load_gnt=0, no write, and load_count is unchanged.
REQ-029 fetch_valid SHALL be fetch_gnt delayed one cycle; fetch_data = mem_rdata while fetch_valid, else 0.
REQ-030 Back-to-back fetches SHALL sustain one grant per cycle (latency 1, throughput 1).
REQ-031 load_count SHALL increment on each load_gnt and saturate at DEPTH.
REQ-032 load_done arriving with load_req in the same cycle: the write SHALL still be granted under BOOT rules, and the state is RUN from the next cycle.
REQ-033 A fetch_req in the same cycle as load_done SHALL NOT be granted.

Reset
REQ-034 On rst assertion, asynchronously: state=BOOT; counter=0; load_count=0; fetch_valid=0; fetch_err=0; running=0.
REQ-035 Combinational grants SHALL be 0 while rst is high.
REQ-036 Reset mid-fetch SHALL suppress the pending fetch_valid.
REQ-037 Reset mid-load SHALL abandon the load; memory contents are not cleared.

Verification
REQ-038 BOOT: writes to 0x0,0x4,0x8 with data 0x00100A93,0x028AAB83,0x01CBFC33 -> three load_gnt pulses, load_count=3; fetch_req at 0x0 not granted.
REQ-039 load_done, then fetches at 0x0,0x4 on consecutive cycles -> fetch_valid on the next two cycles with data 0x00100A93 and 0x028AAB83; running=1.
REQ-040 RUN, fetch_req and load_req held continuously, STARVE_MAX=4 -> 4 fetch grants, then 1 load grant, then fetches resume; the pattern repeats.
REQ-041 Fetch at 0x6, then at 0x1000 -> fetch_err pulse for each; mem_en=0; no fetch_valid.
REQ-042 Load at 0x2 -> no load_gnt, load_count unchanged; then a legal load is granted.
REQ-043 rst asserted mid-cycle during RUN with fetch in flight -> outputs zero immediately, state BOOT, no fetch_valid after release.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Request/response bundle between the core, the boot loader, the arbiter and the
// single-port instruction memory.
interface imem_arbiter_if #(
    parameter int AW = 10
);
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [31:0]   fetch_data;
    logic          fetch_err;

    logic          load_req;
    logic [31:0]   load_addr;
    logic [31:0]   load_data;
    logic          load_gnt;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // arbiter side
    modport slave (
        input  fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
        output fetch_gnt, fetch_valid, fetch_data, fetch_err, load_gnt,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // requesters and memory side
    modport master (
        output fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
        input  fetch_gnt, fetch_valid, fetch_data, fetch_err, load_gnt,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction memory port arbiter: loader-only BOOT phase, then fetch-priority RUN
// phase with a starvation limit that periodically forces a pending load through.
module imem_arbiter #(
    parameter int DEPTH      = 1024,
    parameter int STARVE_MAX = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(STARVE_MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    imem_arbiter_if.slave bus,
    input  logic         load_done,
    output logic         running,
    output logic [AW:0]  load_count
);
    localparam logic [0:0]  BOOT  = 1'b0;
    localparam logic [0:0]  RUN   = 1'b1;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
    localparam logic [AW:0] CMAX  = (AW + 1)'(DEPTH);

    logic [0:0]    state;
    logic [CW-1:0] starve;
    logic          fetch_legal, load_legal, force_load;
    logic          fetch_gnt, load_gnt;
    logic          fetch_vld_q, fetch_err_q;

    always_comb begin
        fetch_legal = (bus.fetch_addr[1:0] == 2'b00) && (bus.fetch_addr < LIMIT);
        load_legal  = (bus.load_addr[1:0] == 2'b00) && (bus.load_addr < LIMIT);
        force_load  = (starve == CW'(STARVE_MAX));
        // BOOT never grants fetches, which also covers a fetch coincident with load_done
        fetch_gnt   = ~rst & (state == RUN) & bus.fetch_req & fetch_legal & ~force_load;
        load_gnt    = ~rst & bus.load_req & load_legal & ~fetch_gnt;
    end

    assign bus.fetch_gnt   = fetch_gnt;
    assign bus.load_gnt    = load_gnt;
    assign bus.mem_en      = fetch_gnt | load_gnt;
    assign bus.mem_we      = load_gnt;
    assign bus.mem_addr    = fetch_gnt ? bus.fetch_addr[AW+1:2] : bus.load_addr[AW+1:2];
    assign bus.mem_wdata   = bus.load_data;
    assign bus.fetch_valid = fetch_vld_q;
    assign bus.fetch_data  = fetch_vld_q ? bus.mem_rdata : 32'h0;
    assign bus.fetch_err   = fetch_err_q;
    assign running         = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            starve      <= '0;
            load_count  <= '0;
            fetch_vld_q <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            if (state == BOOT && load_done)
                state <= RUN;
            fetch_vld_q <= fetch_gnt;
            fetch_err_q <= (state == RUN) & bus.fetch_req & ~fetch_legal;
            // counts fetches that overtook a waiting load; any load win or idle loader resets it
            if (load_gnt || !bus.load_req)
                starve <= '0;
            else if (fetch_gnt)
                starve <= starve + 1'b1;
            if (load_gnt && load_count != CMAX)
                load_count <= load_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: per-cycle compare against a behavioural model
// plus literal checks on the boot, fetch, starvation, error and reset scenarios.
module tb_imem_arbiter;
    localparam int DEPTH      = 1024;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        load_done;
    logic        running;
    logic [10:0] load_count;

    imem_arbiter_if #(.AW(10)) bus ();

    imem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .load_done  (load_done),
        .running    (running),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read memory
    logic [31:0] mem [DEPTH];
    always @(posedge clk)
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * DEPTH);
    endfunction

    // behavioural model
    bit          m_run, m_vld, m_err;
    int          m_starve, m_lcnt;
    logic [31:0] m_data;
    logic [31:0] shadow [DEPTH];
    bit          e_fg, e_lg;
    int          e_idx;

    always_comb begin
        e_fg  = !rst && m_run && bus.fetch_req && legal(bus.fetch_addr) && (m_starve != STARVE_MAX);
        e_lg  = !rst && bus.load_req && legal(bus.load_addr) && !e_fg;
        e_idx = e_fg ? int'((bus.fetch_addr / 4) % DEPTH) : int'((bus.load_addr / 4) % DEPTH);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 0; m_vld <= 0; m_err <= 0; m_starve <= 0; m_lcnt <= 0;
        end else begin
            m_run  <= m_run | load_done;
            m_vld  <= e_fg;
            m_data <= shadow[(bus.fetch_addr / 4) % DEPTH];
            m_err  <= m_run && bus.fetch_req && !legal(bus.fetch_addr);
            if (e_lg) begin
                shadow[e_idx] <= bus.load_data;
                m_lcnt <= (m_lcnt == DEPTH) ? DEPTH : m_lcnt + 1;
            end
            if (e_lg || !bus.load_req) m_starve <= 0;
            else if (e_fg)             m_starve <= m_starve + 1;
        end
    end

    always @(negedge clk) begin
        chk("cmp_fetch_gnt", 32'(bus.fetch_gnt), 32'(e_fg));
        chk("cmp_load_gnt", 32'(bus.load_gnt), 32'(e_lg));
        chk("cmp_mem_en", 32'(bus.mem_en), 32'(e_fg | e_lg));
        chk("cmp_mem_we", 32'(bus.mem_we), 32'(e_lg));
        if (e_fg || e_lg) chk("cmp_mem_addr", 32'(bus.mem_addr), 32'(e_idx));
        if (e_lg)         chk("cmp_mem_wdata", bus.mem_wdata, bus.load_data);
        chk("cmp_fetch_valid", 32'(bus.fetch_valid), 32'(m_vld));
        chk("cmp_fetch_data", bus.fetch_data, m_vld ? m_data : 32'h0);
        chk("cmp_fetch_err", 32'(bus.fetch_err), 32'(m_err));
        chk("cmp_running", 32'(running), 32'(m_run));
        chk("cmp_load_count", 32'(load_count), 32'(m_lcnt));
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    logic [31:0] img [3];
    logic [9:0]  fpat, lpat;

    initial begin
        img[0] = 32'h00100A93; img[1] = 32'h028AAB83; img[2] = 32'h01CBFC33;
        rst = 1'b1; load_done = 1'b0;
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
        bus.load_req = 1'b1; bus.load_addr = 32'h40; bus.load_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_load_count", 32'(load_count), 32'h0);
        chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'h0);
        chk("rst_grants", {30'h0, bus.fetch_gnt, bus.load_gnt}, 32'h0);
        bus.fetch_req = 1'b0; bus.load_req = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();

        // boot image; fetch held and refused
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            bus.load_req = 1'b1; bus.load_addr = 32'(4 * i); bus.load_data = img[i];
            #1;
            chk("boot_fetch_gnt", 32'(bus.fetch_gnt), 32'h0);
            chk("boot_load_gnt", 32'(bus.load_gnt), 32'h1);
            cyc();
        end
        bus.load_req = 1'b0;
        chk("boot_load_count", 32'(load_count), 32'd3);

        // misaligned load dropped, then legal load
        bus.load_req = 1'b1; bus.load_addr = 32'h2; bus.load_data = 32'hBAD0BAD0;
        #1 chk("bad_load_gnt", 32'(bus.load_gnt), 32'h0);
        cyc();
        chk("bad_load_count", 32'(load_count), 32'd3);
        bus.load_addr = 32'hC; bus.load_data = 32'hDEADBEEF;
        #1 chk("good_load_gnt", 32'(bus.load_gnt), 32'h1);
        cyc();
        chk("good_load_count", 32'(load_count), 32'd4);

        // load_done together with a load and a fetch
        bus.load_addr = 32'h10; bus.load_data = 32'h12345678; load_done = 1'b1;
        #1;
        chk("done_fetch_gnt", 32'(bus.fetch_gnt), 32'h0);
        chk("done_load_gnt", 32'(bus.load_gnt), 32'h1);
        chk("done_running", 32'(running), 32'h0);
        cyc();
        load_done = 1'b0; bus.load_req = 1'b0;
        chk("run_running", 32'(running), 32'h1);
        chk("run_load_count", 32'(load_count), 32'd5);

        // back-to-back fetches at 0x0, 0x4
        cyc();
        bus.fetch_addr = 32'h4;
        #1;
        chk("fetch0_valid", 32'(bus.fetch_valid), 32'h1);
        chk("fetch0_data", bus.fetch_data, 32'h00100A93);
        cyc();
        bus.fetch_req = 1'b0;
        #1;
        chk("fetch1_valid", 32'(bus.fetch_valid), 32'h1);
        chk("fetch1_data", bus.fetch_data, 32'h028AAB83);
        cyc();

        // starvation limit
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h8;
        bus.load_req = 1'b1; bus.load_addr = 32'h20; bus.load_data = 32'hCAFEF00D;
        for (int i = 0; i < 10; i++) begin
            #1;
            fpat[9-i] = bus.fetch_gnt;
            lpat[9-i] = bus.load_gnt;
            cyc();
        end
        bus.fetch_req = 1'b0; bus.load_req = 1'b0;
        chk("starve_fetch_pattern", 32'(fpat), 32'(10'b1111011110));
        chk("starve_load_pattern", 32'(lpat), 32'(10'b0000100001));
        chk("starve_load_count", 32'(load_count), 32'd7);

        // illegal fetches
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h6;
        #1;
        chk("err6_gnt", 32'(bus.fetch_gnt), 32'h0);
        chk("err6_mem_en", 32'(bus.mem_en), 32'h0);
        cyc();
        bus.fetch_addr = 32'h1000;
        #1;
        chk("err6_pulse", 32'(bus.fetch_err), 32'h1);
        chk("err1000_gnt", 32'(bus.fetch_gnt), 32'h0);
        chk("err1000_mem_en", 32'(bus.mem_en), 32'h0);
        cyc();
        bus.fetch_req = 1'b0;
        #1;
        chk("err1000_pulse", 32'(bus.fetch_err), 32'h1);
        chk("err_no_valid", 32'(bus.fetch_valid), 32'h0);
        cyc();
        #1 chk("err_cleared", 32'(bus.fetch_err), 32'h0);
        cyc();

        // reset with a fetch in flight
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4;
        cyc();
        #1 chk("inflight_valid", 32'(bus.fetch_valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.fetch_valid), 32'h0);
        chk("midrst_running", 32'(running), 32'h0);
        chk("midrst_fetch_gnt", 32'(bus.fetch_gnt), 32'h0);
        chk("midrst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("midrst_load_count", 32'(load_count), 32'h0);
        bus.fetch_req = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        #1 chk("postrst_valid", 32'(bus.fetch_valid), 32'h0);
        cyc();

        // memory contents survive reset
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0; load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        cyc();
        #1;
        chk("retained_valid", 32'(bus.fetch_valid), 32'h1);
        chk("retained_data", bus.fetch_data, 32'h00100A93);
        bus.fetch_req = 1'b0;
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
